// File: rtl/serial_alu_sched.sv
// Bit-serial scheduler: round-robin arbitration between two requesters that share
// one single-bit ALU, streaming operands LSB-first and reassembling the result.
module serial_alu_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [1:0]       sel0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [1:0]       sel1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result,
   output logic             alu_a,
   output logic             alu_b,
   output logic [1:0]       alu_sel,
   input  logic             alu_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [1:0]       sel_q;
   logic             id_q;
   logic             last_id;
   logic [CW-1:0]    cnt;
   logic             any_req;
   logic             winner;
   logic             last_bit;

   // On a tie the requester that did not win last time is served.
   always_comb begin
      any_req  = req0 | req1;
      winner   = (req0 & req1) ? ~last_id : req1;
      last_bit = (cnt == CNT_LAST);
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = RUN;
         RUN:     if (last_bit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         r_sh    <= '0;
         sel_q   <= '0;
         id_q    <= 1'b0;
         last_id <= 1'b1;
         cnt     <= '0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         result  <= '0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  a_sh    <= winner ? a1 : a0;
                  b_sh    <= winner ? b1 : b0;
                  sel_q   <= winner ? sel1 : sel0;
                  id_q    <= winner;
                  last_id <= winner;
                  gnt0    <= ~winner;
                  gnt1    <= winner;
                  cnt     <= '0;
               end
            end
            RUN: begin
               r_sh <= {alu_out, r_sh[WIDTH-1:1]};
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + CW'(1);
               if (last_bit) begin
                  result  <= {alu_out, r_sh[WIDTH-1:1]};
                  done    <= 1'b1;
                  done_id <= id_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

   always_comb begin
      alu_a   = 1'b0;
      alu_b   = 1'b0;
      alu_sel = 2'b00;
      if (state == RUN) begin
         alu_a   = a_sh[0];
         alu_b   = b_sh[0];
         alu_sel = sel_q;
      end
   end

endmodule

// File: tb/tb_serial_alu_sched.sv
// Self-checking bench for serial_alu_sched: a transaction-level reference model
// predicts grants and results into a scoreboard; a monitor compares every cycle.
module tb_serial_alu_sched;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         req0, req1;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   sel0, sel1;
   logic         gnt0, gnt1, busy, done, done_id;
   logic [W-1:0] result;
   logic         alu_a, alu_b, alu_out;
   logic [1:0]   alu_sel;

   int errors = 0;
   int checks = 0;

   serial_alu_sched #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0), .sel0(sel0),
      .req1(req1), .a1(a1), .b1(b1), .sel1(sel1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
      .result(result), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out)
   );

   // The shared one-bit ALU.
   always_comb begin
      case (alu_sel)
         2'b00:   alu_out = alu_a & alu_b;
         2'b01:   alu_out = alu_a | alu_b;
         2'b10:   alu_out = alu_a ^ alu_b;
         default: alu_out = ~alu_a;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [1:0] s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (s)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic         id;
      logic [W-1:0] res;
   } exp_t;

   exp_t         sb[$];
   longint       m_edge = 0;
   longint       m_g = -100;
   logic         m_last = 1'b1;
   logic         m_id = 1'b0;
   logic [W-1:0] m_a = '0, m_b = '0, m_res = '0, m_cur = '0;
   logic [1:0]   m_sel = '0;
   logic         x_gnt0 = 0, x_gnt1 = 0, x_busy = 0, x_done = 0, x_run = 0;
   logic         x_alu_a = 0, x_alu_b = 0;
   logic [1:0]   x_alu_sel = '0;

   // An operation granted at edge g runs through edge g+W-1 (bits), completes at
   // edge g+W, and the next grant can be no earlier than edge g+W+2.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_edge = 0; m_g = -100; m_last = 1'b1; m_res = '0;
         sb.delete();
         x_gnt0 = 0; x_gnt1 = 0; x_busy = 0; x_done = 0; x_run = 0;
         x_alu_a = 0; x_alu_b = 0; x_alu_sel = '0;
      end else begin
         m_edge++;
         if (m_edge >= m_g + W + 2 && (req0 || req1)) begin
            logic win;
            exp_t e;
            win    = (req0 && req1) ? ~m_last : req1;
            m_g    = m_edge;
            m_last = win;
            m_id   = win;
            m_a    = win ? a1 : a0;
            m_b    = win ? b1 : b0;
            m_sel  = win ? sel1 : sel0;
            m_cur  = ref_op(m_sel, m_a, m_b);
            e.id   = win;
            e.res  = m_cur;
            sb.push_back(e);
         end
         x_gnt0 = (m_edge == m_g) && !m_id;
         x_gnt1 = (m_edge == m_g) && m_id;
         x_busy = (m_edge >= m_g) && (m_edge <= m_g + W);
         x_run  = (m_edge >= m_g) && (m_edge < m_g + W);
         x_done = (m_edge == m_g + W);
         if (x_done) m_res = m_cur;
         x_alu_a   = x_run ? m_a[int'(m_edge - m_g)] : 1'b0;
         x_alu_b   = x_run ? m_b[int'(m_edge - m_g)] : 1'b0;
         x_alu_sel = x_run ? m_sel : 2'b00;
      end
   end

   // ---------------- monitor ----------------
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         check("gnt0", 32'(gnt0), 32'(x_gnt0));
         check("gnt1", 32'(gnt1), 32'(x_gnt1));
         check("busy", 32'(busy), 32'(x_busy));
         check("done", 32'(done), 32'(x_done));
         check("alu_a", 32'(alu_a), 32'(x_alu_a));
         check("alu_b", 32'(alu_b), 32'(x_alu_b));
         check("alu_sel", 32'(alu_sel), 32'(x_alu_sel));
         check("result_hold", 32'(result), 32'(m_res));
         if (done) begin
            if (sb.size() == 0) begin
               check("done_without_expected_op", 32'(1), 32'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("done_id", 32'(done_id), 32'(e.id));
               check("result", 32'(result), 32'(e.res));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_gnt(input logic which);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((which ? gnt1 : gnt0) === 1'b1) return;
      end
      check(which ? "gnt1_timeout" : "gnt0_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_any(output logic who);
      who = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
            who = gnt1;
            return;
         end
      end
      check("gnt_any_timeout", 32'(0), 32'(1));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic   who;
      logic   order[4];
      int     busy_cnt;
      int     g1_cnt;
      rst_n = 1'b0;
      req0 = 0; req1 = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; sel0 = '0; sel1 = '0;
      #1;
      check("rst_result", 32'(result), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_gnt", 32'({gnt0, gnt1, done_id}), 32'(0));
      check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'(0));
      #20 rst_n = 1'b1;
      idle_cycles(20);

      // Single request from requester 0: AND F0,3C.
      @(negedge clk); #1;
      a0 = 8'hF0; b0 = 8'h3C; sel0 = 2'b00; req0 = 1;
      wait_gnt(1'b0);
      #1 req0 = 0;
      busy_cnt = 1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      check("single_busy_cycles", 32'(busy_cnt), 32'(W + 1));
      check("single_result", 32'(result), 32'h30);
      check("single_done_id", 32'(done_id), 32'(0));

      // Simultaneous requests after reset: requester 0 wins the first tie.
      do_reset();
      @(negedge clk); #1;
      a0 = 8'hA5; b0 = 8'hFF; sel0 = 2'b10;
      a1 = 8'h0F; b1 = 8'hF0; sel1 = 2'b01;
      req0 = 1; req1 = 1;
      wait_any(who);
      check("tie_first_winner", 32'(who), 32'(0));
      #1 req0 = 0;
      wait_gnt(1'b1);
      #1 req1 = 0;
      check("tie_first_result", 32'(result), 32'h5A);
      check("tie_first_id", 32'(done_id), 32'(0));
      idle_cycles(W + 2);
      check("tie_second_result", 32'(result), 32'hFF);
      check("tie_second_id", 32'(done_id), 32'(1));

      // Sustained contention: grants must alternate 0,1,0,1.
      @(negedge clk); #1;
      a0 = 8'($urandom); b0 = 8'($urandom); sel0 = 2'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); sel1 = 2'($urandom);
      req0 = 1; req1 = 1;
      for (int k = 0; k < 4; k++) begin
         wait_any(order[k]);
         #1;
         if (order[k]) begin a1 = 8'($urandom); b1 = 8'($urandom); sel1 = 2'($urandom); end
         else          begin a0 = 8'($urandom); b0 = 8'($urandom); sel0 = 2'($urandom); end
      end
      req0 = 0; req1 = 0;
      for (int k = 0; k < 4; k++) check($sformatf("rr_order_%0d", k), 32'(order[k]), 32'(k % 2));
      idle_cycles(W + 4);

      // Reset during RUN after three bits aborts the operation.
      @(negedge clk); #1;
      a0 = 8'h3C; b0 = 8'h0F; sel0 = 2'b01; req0 = 1;
      wait_gnt(1'b0);
      #1 req0 = 0;
      idle_cycles(3);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_result", 32'(result), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_alu_sel", 32'(alu_sel), 32'(0));
      @(negedge clk); #2 rst_n = 1'b1;
      idle_cycles(W + 2);
      @(negedge clk); #1;
      a1 = 8'h55; b1 = 8'($urandom); sel1 = 2'b11; req1 = 1;
      wait_gnt(1'b1);
      #1 req1 = 0;
      idle_cycles(W + 2);
      check("not_a_result", 32'(result), 32'hAA);
      check("not_a_id", 32'(done_id), 32'(1));

      // Requester 1 raised and dropped while busy is never served.
      @(negedge clk); #1;
      a0 = 8'($urandom); b0 = 8'($urandom); sel0 = 2'b11; req0 = 1;
      wait_gnt(1'b0);
      #1 req0 = 0;
      g1_cnt = 0;
      @(negedge clk); #1;
      a1 = 8'($urandom); sel1 = 2'b11; req1 = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (gnt1) g1_cnt++;
      end
      #1 req1 = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (gnt1) g1_cnt++;
      end
      check("dropped_req1_gnts", 32'(g1_cnt), 32'(0));

      // Random request traffic.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         if ($urandom_range(0, 3) == 0) req0 = ~req0;
         if ($urandom_range(0, 3) == 0) req1 = ~req1;
         if (!req0) begin a0 = 8'($urandom); b0 = 8'($urandom); sel0 = 2'($urandom); end
         if (!req1) begin a1 = 8'($urandom); b1 = 8'($urandom); sel1 = 2'($urandom); end
      end
      req0 = 0; req1 = 0;
      idle_cycles(W + 6);
      check("scoreboard_drained", 32'(sb.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
